serial_subtractor: RTL and testbench

//   Bit-serial two's-complement subtractor: computes diff = a - b - bin, one bit per clock, LSB first,

---
 rtl/serial_subtractor_if.sv | 26 ++
 rtl/serial_subtractor.sv | 89 ++++++++
 tb/tb_serial_subtractor.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// Operands travel on the in_* side, the completed result on the out_* side.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, through one full-subtractor cell and a borrow register.
// Latency: out_valid rises WIDTH edges after the accepting edge; one op per WIDTH+2 cycles.
// Backpressure: the result is held in DONE for as long as out_ready stays low; no new operands meanwhile.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   io
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_q;
    logic             borrow;
    logic             bout_q;
    logic             ovf_q;
    logic [CW-1:0]    cnt;

    logic ai;
    logic bi;
    logic d_bit;
    logic bo_bit;

    // Full-subtractor cell on the current LSBs and the registered borrow.
    always_comb begin
        ai     = a_sr[0];
        bi     = b_sr[0];
        d_bit  = ai ^ bi ^ borrow;
        bo_bit = (~ai & bi) | (~(ai ^ bi) & borrow);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            diff_q <= '0;
            borrow <= 1'b0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (io.in_valid) begin
                        a_sr   <= io.a;
                        b_sr   <= io.b;
                        borrow <= io.bin;
                        cnt    <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    diff_q <= {d_bit, diff_q[WIDTH-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    borrow <= bo_bit;
                    if (cnt == CW'(WIDTH - 1)) begin
                        // Signed overflow: borrow into the sign bit differs from borrow out of it.
                        ovf_q  <= borrow ^ bo_bit;
                        bout_q <= bo_bit;
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (io.out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign io.in_ready  = (state == S_IDLE);
    assign io.out_valid = (state == S_DONE);
    assign io.diff      = diff_q;
    assign io.bout      = bout_q;
    assign io.ovf       = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and model-checked bench for serial_subtractor at WIDTH=8, plus an exhaustive WIDTH=2 sweep.
module tb_serial_subtractor;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    serial_subtractor_if #(.WIDTH(8)) if8 ();
    serial_subtractor_if #(.WIDTH(2)) if2 ();

    serial_subtractor #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .io(if8.slave));
    serial_subtractor #(.WIDTH(2)) u_dut2 (.clk(clk), .rst(rst), .io(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {ovf, bout, diff} from plain integer arithmetic.
    function automatic logic [9:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        int u;
        int s;
        logic [7:0] d;
        logic bo;
        logic ov;
        u  = int'(a) - int'(b) - int'(bin);
        s  = int'($signed(a)) - int'($signed(b)) - int'(bin);
        d  = u[7:0];
        bo = (u < 0);
        ov = (s < -128) || (s > 127);
        return {ov, bo, d};
    endfunction

    function automatic logic [3:0] ref2(input logic [1:0] a, input logic [1:0] b, input logic bin);
        int u;
        int s;
        logic [1:0] d;
        u = int'(a) - int'(b) - int'(bin);
        s = int'($signed(a)) - int'($signed(b)) - int'(bin);
        d = u[1:0];
        return {(s < -2) || (s > 1), u < 0, d};
    endfunction

    task automatic run_op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bin,
                           input logic [7:0] ed, input logic eb, input logic eo,
                           input int gap, input int hold, input logic poke);
        int n;
        repeat (gap) tick();
        n = 0;
        while (!if8.in_ready && n < 50) begin tick(); n++; end
        check({tag, "_in_ready"}, 32'(if8.in_ready), 32'd1);
        if8.a = a; if8.b = b; if8.bin = bin; if8.in_valid = 1'b1;
        tick();
        if8.in_valid = 1'b0;
        if8.a = 8'($urandom); if8.b = 8'($urandom); if8.bin = 1'($urandom);
        n = 0;
        while (!if8.out_valid && n < 50) begin tick(); n++; end
        check({tag, "_latency"}, 32'(n), 32'd8);
        check({tag, "_diff"}, 32'(if8.diff), 32'(ed));
        check({tag, "_bout"}, 32'(if8.bout), 32'(eb));
        check({tag, "_ovf"}, 32'(if8.ovf), 32'(eo));
        for (int i = 0; i < hold; i++) begin
            if8.in_valid = poke && (i == 1);
            tick();
            check({tag, "_hold"}, 32'({if8.out_valid, if8.in_ready, if8.bout, if8.ovf, if8.diff}),
                  32'({1'b1, 1'b0, eb, eo, ed}));
        end
        if8.in_valid  = 1'b0;
        if8.out_ready = 1'b1;
        tick();
        if8.out_ready = 1'b0;
        check({tag, "_handoff"}, 32'({if8.in_ready, if8.out_valid}), 32'b10);
    endtask

    task automatic run_op2(input logic [1:0] a, input logic [1:0] b, input logic bin);
        int n;
        logic [3:0] e;
        e = ref2(a, b, bin);
        if2.a = a; if2.b = b; if2.bin = bin; if2.in_valid = 1'b1;
        tick();
        if2.in_valid = 1'b0;
        n = 0;
        while (!if2.out_valid && n < 20) begin tick(); n++; end
        check("w2_latency", 32'(n), 32'd2);
        check($sformatf("w2_a%0d_b%0d_bin%0d", a, b, bin), 32'({if2.ovf, if2.bout, if2.diff}), 32'(e));
        if2.out_ready = 1'b1;
        tick();
        if2.out_ready = 1'b0;
        check("w2_handoff", 32'(if2.in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbin;
        logic [9:0] e;
        int         n;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.bin = 1'b0; if8.out_ready = 1'b0;
        if2.in_valid = 1'b0; if2.a = '0; if2.b = '0; if2.bin = 1'b0; if2.out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_state", 32'({if8.in_ready, if8.out_valid, if8.bout, if8.ovf, if8.diff}),
              32'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));

        run_op8("t1",  8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 0, 0, 1'b0);
        run_op8("t2",  8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1, 0, 1'b0);
        run_op8("t3a", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0, 0, 1'b0);
        run_op8("t3b", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 0, 0, 1'b0);
        run_op8("t4",  8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0, 0, 5, 1'b1);

        // Reset on the 4th RUN edge discards the operation.
        if8.a = 8'h33; if8.b = 8'h11; if8.bin = 1'b0; if8.in_valid = 1'b1;
        tick();
        if8.in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_after_rst", 32'({if8.in_ready, if8.out_valid, if8.diff}), 32'({1'b1, 1'b0, 8'h00}));
        n = 0;
        repeat (12) begin tick(); if (if8.out_valid) n++; end
        check("t5_no_out_valid", 32'(n), 32'd0);
        run_op8("t5",  8'h0A, 8'h14, 1'b0, 8'hF6, 1'b1, 1'b0, 0, 0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            if (i < 4) begin
                ra = (i < 2) ? 8'h80 : 8'h7F;
                rb = (i[0]) ? 8'h7F : 8'h80;
            end
            e = ref8(ra, rb, rbin);
            run_op8($sformatf("rnd%0d", i), ra, rb, rbin, e[7:0], e[8], e[9],
                    $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
        end

        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 2; c++)
                    run_op2(2'(a), 2'(b), 1'(c));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
